// File: rtl/rv_imm_pkg.sv
// Shared opcode constants, format tags and the immediate decoder for rv_imm_stage.
// Build option IMM_CSR_EN: CSR-immediate SYSTEM ops decode as fmt Z (zimm in ir[19:15]).
package rv_imm_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        fmt_t        fmt;
        logic [63:0] imm;
        logic        illegal;
    } imm_res_t;

    // Immediate is always produced at 64 bits; XLEN=32 users keep the low half.
    function automatic imm_res_t imm_decode(input logic [31:0] ir, input logic xlen64);
        imm_res_t   r;
        logic [2:0] funct3;
        logic       is_shift;
        funct3    = ir[14:12];
        is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
        r.fmt     = FMT_NONE;
        r.imm     = '0;
        r.illegal = 1'b0;
        case (ir[6:0])
            OPC_LOAD, OPC_JALR: begin
                r.fmt = FMT_I;
                r.imm = {{52{ir[31]}}, ir[31:20]};
            end
            OPC_OP_IMM: begin
                r.fmt = FMT_I;
                if (is_shift) r.imm = xlen64 ? {58'b0, ir[25:20]} : {59'b0, ir[24:20]};
                else          r.imm = {{52{ir[31]}}, ir[31:20]};
            end
            OPC_OP_IMM32: begin
                r.fmt     = FMT_I;
                r.illegal = !xlen64;
                if (is_shift) r.imm = {59'b0, ir[24:20]};
                else          r.imm = {{52{ir[31]}}, ir[31:20]};
            end
            OPC_STORE: begin
                r.fmt = FMT_S;
                r.imm = {{52{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OPC_BRANCH: begin
                r.fmt = FMT_B;
                r.imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                r.fmt = FMT_U;
                r.imm = {{32{ir[31]}}, ir[31:12], 12'b0};
            end
            OPC_JAL: begin
                r.fmt = FMT_J;
                r.imm = {{43{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OPC_OP: ;
            OPC_OP32: r.illegal = !xlen64;
            OPC_SYSTEM: begin
`ifdef IMM_CSR_EN
                if (funct3 != 3'b000) begin
                    r.fmt = FMT_Z;
                    r.imm = {59'b0, ir[19:15]};
                end else begin
                    r.fmt = FMT_I;
                    r.imm = {{52{ir[31]}}, ir[31:20]};
                end
`else
                r.fmt = FMT_I;
                r.imm = {{52{ir[31]}}, ir[31:20]};
`endif
            end
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv_imm_if.sv
// Handshake bundle of rv_imm_stage: instruction/PC in, decoded bundle out, plus flush.
interface rv_imm_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ir;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_ir;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_ir, out_pc, out_imm, out_fmt, out_target, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_ir, out_pc, out_imm, out_fmt, out_target, out_illegal
    );
endinterface

// File: rtl/rv_imm_skid.sv
// Two-entry skid buffer (main drives the outputs, skid absorbs one extra word); registered in_ready.
//  state      | meaning
//  SKID_EMPTY | main and skid invalid
//  SKID_ONE   | main valid, skid invalid
//  SKID_FULL  | main and skid valid, upstream blocked
module rv_skid_buf
    import rv_imm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         in_ready_q;
    logic         accept, drain;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = main_q;
    assign accept      = in_valid_i & in_ready_q;
    assign drain       = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_d = SKID_ONE;
                    main_d  = in_data_i;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    main_d = in_data_i;
                end else if (accept) begin
                    state_d = SKID_FULL;
                    skid_d  = in_data_i;
                end else if (drain) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (drain) begin
                    state_d = SKID_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        if (flush_i) state_d = SKID_EMPTY;
    end

    // in_ready is the registered image of "next state is not FULL".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SKID_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != SKID_FULL);
        end
    end
endmodule

// File: rtl/rv_imm_stage.sv
// Registered immediate-decode stage: decodes and adds on the input side, holds results in a skid buffer.
// Build option IMM_CSR_EN selects CSR-immediate (fmt Z) decoding for SYSTEM ops.
module rv_imm_stage
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic      clk,
    input logic      rst,
    rv_imm_if.slave  bus_io
);
    typedef struct packed {
        logic [31:0]     ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } payload_t;

    imm_res_t        dec;
    logic [XLEN-1:0] imm_x;
    logic            has_target;
    logic            unused_dec_imm;
    payload_t        in_p, out_p;

    assign dec            = imm_decode(bus_io.in_ir, XLEN == 64);
    assign imm_x          = dec.imm[XLEN-1:0];
    assign unused_dec_imm = ^dec.imm;
    assign has_target     = (dec.fmt == FMT_B) || (dec.fmt == FMT_J)
                          || (bus_io.in_ir[6:0] == OPC_AUIPC);

    always_comb begin
        in_p.ir      = bus_io.in_ir;
        in_p.pc      = bus_io.in_pc;
        in_p.imm     = imm_x;
        in_p.fmt     = dec.fmt;
        in_p.target  = has_target ? (bus_io.in_pc + imm_x) : '0;
        in_p.illegal = dec.illegal;
    end

    rv_skid_buf #(.W($bits(payload_t))) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (bus_io.flush),
        .in_valid_i  (bus_io.in_valid),
        .in_ready_o  (bus_io.in_ready),
        .in_data_i   (in_p),
        .out_valid_o (bus_io.out_valid),
        .out_ready_i (bus_io.out_ready),
        .out_data_o  (out_p)
    );

    assign bus_io.out_ir      = out_p.ir;
    assign bus_io.out_pc      = out_p.pc;
    assign bus_io.out_imm     = out_p.imm;
    assign bus_io.out_fmt     = out_p.fmt;
    assign bus_io.out_target  = out_p.target;
    assign bus_io.out_illegal = out_p.illegal;
endmodule
